// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder family.
package adder_pkg;

  localparam int ADDER_W = 4;

endpackage

// File: rtl/adder_4_full_adder.sv
// Single-bit full adder; the ripple chain in adder_4 is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_4.sv
// Registered ripple-carry adder with carry-in, unsigned carry-out and signed
// overflow. The result appears one cycle after the operands are sampled.
module adder_4
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovout
);

  // Valid semantics: in_valid qualifies A/B/Cin on the sampling edge, and
  // out_valid is high for exactly one cycle per accepted operand set, one
  // cycle later. There is no ready; the block accepts every cycle.

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ov;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // Carries into and out of the sign bit disagree exactly on signed overflow.
  assign w_ov = w_c[WIDTH] ^ w_c[WIDTH-1];

  logic             r_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[WIDTH];
        r_ov   <= w_ov;
      end
    end
  end

  assign out_valid = r_valid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign Ovout     = r_ov;

endmodule

// File: tb/tb_adder_4.sv
// Self-checking bench for adder_4: directed corner cases, hold, reset and a
// randomized back-to-back run against an arithmetic reference model.
module tb_adder_4;
  import adder_pkg::*;

  localparam int W  = ADDER_W;
  localparam int RW = W + 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] s_out;
  logic         cout;
  logic         ovout;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_exp;

  adder_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a_in),
    .B         (b_in),
    .Cin       (cin),
    .out_valid (out_valid),
    .S         (s_out),
    .Cout      (cout),
    .Ovout     (ovout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Packed as {cout, ovout, s}.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
    int usum;
    int sa;
    int sb;
    int ssum;
    logic [W-1:0] s;
    logic co;
    logic ov;
    usum = int'(a) + int'(b) + int'(c);
    sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ssum = sa + sb + int'(c);
    s    = W'(usum % (1 << W));
    co   = (usum >= (1 << W));
    ov   = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
    return {co, ov, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    @(posedge clk);
    #1;
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = c;
    if (v) begin
      exp_q.push_back(model(a, b, c));
      last_exp = model(a, b, c);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("sum",  32'(s_out), 32'(e[W-1:0]));
        check("cout", 32'(cout),  32'(e[W+1]));
        check("ovf",  32'(ovout), 32'(e[W]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    cin      = 1'b1;
    last_exp = '0;

    // Reset held with active inputs: everything stays zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_s",     32'(s_out),     32'd0);
    check("rst_cout",  32'(cout),      32'd0);
    check("rst_ovf",   32'(ovout),     32'd0);

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed corner cases.
    drive(1'b1, W'(0),  W'(0),  1'b0);
    drive(1'b1, W'(4),  W'(8),  1'b1);
    drive(1'b1, W'(7),  W'(8),  1'b1);
    drive(1'b1, W'(12), W'(9),  1'b0);
    drive(1'b1, W'(7),  W'(1),  1'b0);
    drive(1'b1, W'(15), W'(15), 1'b1);

    // Idle with changing operands: outputs hold, out_valid drops.
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    #2;
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_s",     32'(s_out),     32'(last_exp[W-1:0]));
    check("hold_cout",  32'(cout),      32'(last_exp[W+1]));
    check("hold_ovf",   32'(ovout),     32'(last_exp[W]));

    // Mid-stream reset: an in-flight operand is dropped, outputs clear at once.
    drive(1'b1, W'(5), W'(6), 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_s",     32'(s_out),     32'd0);
    check("async_rst_cout",  32'(cout),      32'd0);
    check("async_rst_ovf",   32'(ovout),     32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Randomized run, mostly back-to-back.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            1'($urandom));
    end
    drive(1'b0, '0, '0, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
